data_mem_read_arbiter: RTL

//   Shares the single read port of the data-memory BSRAM between the CPU load

---
 rtl/data_mem_read_arbiter_if.sv | 38 +++
 rtl/data_mem_read_arbiter.sv | 93 +++++++++
 2 files changed

// File: rtl/data_mem_read_arbiter_if.sv
// Bundle of the CPU load port, the copy-controller read port and the BSRAM
// read port that the data-memory read arbiter sits between.
interface data_mem_read_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  cpu_req;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  logic                  copy_req;
  logic [ADDR_WIDTH-1:0] copy_addr;
  logic                  copy_gnt;
  logic                  copy_rvalid;
  logic [DATA_WIDTH-1:0] copy_rdata;

  logic [ADDR_WIDTH-1:0] mem_dout_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  cpu_starve;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_addr, copy_req, copy_addr, mem_dout,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output copy_gnt, copy_rvalid, copy_rdata,
    output mem_dout_addr, cpu_starve
  );

  // Requester / memory side.
  modport master (
    output cpu_req, cpu_addr, copy_req, copy_addr, mem_dout,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  copy_gnt, copy_rvalid, copy_rdata,
    input  mem_dout_addr, cpu_starve
  );
endinterface

// File: rtl/data_mem_read_arbiter.sv
// Shares the BSRAM read port between the copy controller (priority) and the CPU,
// with a starvation escape for the CPU and a tag pipe that steers returning data.
module data_mem_read_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  data_mem_read_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]           starve_cnt_q, starve_cnt_d;
  logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
  logic                    post_rst_q, post_rst_d;
  logic [READ_LATENCY-1:0] tag_v_q, tag_v_d;
  logic [READ_LATENCY-1:0] tag_cpu_q, tag_cpu_d;

  logic blocked;
  logic force_cpu;
  logic cpu_gnt;
  logic copy_gnt;
  logic cpu_rvalid;
  logic copy_rvalid;

  // No grants during reset nor on the cycle right after it.
  always_comb begin
    blocked    = reset | post_rst_q;
    force_cpu  = !blocked && bus.cpu_req && (starve_cnt_q == LIMIT);
    copy_gnt   = !blocked && bus.copy_req && !force_cpu;
    cpu_gnt    = !blocked && bus.cpu_req && (!bus.copy_req || force_cpu);
    post_rst_d = reset;

    last_addr_d = last_addr_q;
    if (cpu_gnt) begin
      last_addr_d = bus.cpu_addr;
    end else if (copy_gnt) begin
      last_addr_d = bus.copy_addr;
    end

    starve_cnt_d = starve_cnt_q;
    if (blocked || !bus.cpu_req || cpu_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  // Tag pipe: one {valid, owner} stage per cycle of BSRAM read latency.
  for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      assign tag_v_d[gi]   = cpu_gnt | copy_gnt;
      assign tag_cpu_d[gi] = cpu_gnt;
    end else begin : g_body
      assign tag_v_d[gi]   = tag_v_q[gi-1];
      assign tag_cpu_d[gi] = tag_cpu_q[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      last_addr_q  <= '0;
      post_rst_q   <= 1'b1;
      tag_v_q      <= '0;
      tag_cpu_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      last_addr_q  <= last_addr_d;
      post_rst_q   <= post_rst_d;
      tag_v_q      <= tag_v_d;
      tag_cpu_q    <= tag_cpu_d;
    end
  end

  // Returns still in the pipe when reset rises are suppressed immediately.
  always_comb begin
    cpu_rvalid  = !reset && tag_v_q[READ_LATENCY-1] &&  tag_cpu_q[READ_LATENCY-1];
    copy_rvalid = !reset && tag_v_q[READ_LATENCY-1] && !tag_cpu_q[READ_LATENCY-1];

    bus.cpu_gnt       = cpu_gnt;
    bus.copy_gnt      = copy_gnt;
    bus.cpu_starve    = force_cpu;
    bus.mem_dout_addr = last_addr_d;
    bus.cpu_rvalid    = cpu_rvalid;
    bus.copy_rvalid   = copy_rvalid;
    bus.cpu_rdata     = cpu_rvalid  ? bus.mem_dout : '0;
    bus.copy_rdata    = copy_rvalid ? bus.mem_dout : '0;
  end
endmodule
